// File: rtl/rvv_pkg.sv
// Shared vector-unit definitions: register width, vsew/vlmul encodings,
// encoding legality checks and the LMUL to register-count decode.
package rvv_pkg;

  localparam int unsigned Vlen = 128;

  // vsew encodings
  localparam logic [2:0] SewE8  = 3'b000;
  localparam logic [2:0] SewE16 = 3'b001;
  localparam logic [2:0] SewE32 = 3'b010;
  localparam logic [2:0] SewE64 = 3'b011;

  // vlmul encodings; 101/110/111 are fractional and occupy one register
  localparam logic [2:0] LmulM1   = 3'b000;
  localparam logic [2:0] LmulM2   = 3'b001;
  localparam logic [2:0] LmulM4   = 3'b010;
  localparam logic [2:0] LmulM8   = 3'b011;
  localparam logic [2:0] LmulRsvd = 3'b100;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StFinish
  } wb_state_e;

  function automatic logic sew_legal(input logic [2:0] enc);
    return enc[2] == 1'b0;
  endfunction

  function automatic logic lmul_legal(input logic [2:0] enc);
    return enc != LmulRsvd;
  endfunction

  // Number of registers in the group (1..8)
  function automatic logic [3:0] lmul_nregs(input logic [2:0] enc);
    logic [3:0] n;
    case (enc)
      LmulM2:  n = 4'd2;
      LmulM4:  n = 4'd4;
      LmulM8:  n = 4'd8;
      default: n = 4'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/vwb_tail_mask.sv
// Combinational tail mask for one writeback beat. Every SEW-wide element whose
// group-wide index (beat * elems_per_reg + k) is >= vl is forced to all ones.
// Ports:
//   in_data  - raw result beat
//   sew      - vsew encoding, low two bits (8/16/32/64)
//   beat     - register index within the group (0..7)
//   vl       - active vector length
//   out_data - tail-masked beat
module vwb_tail_mask
  import rvv_pkg::*;
(
  input  logic [Vlen-1:0] in_data,
  input  logic [1:0]      sew,
  input  logic [2:0]      beat,
  input  logic [8:0]      vl,
  output logic [Vlen-1:0] out_data
);

  logic [Vlen-1:0] m8, m16, m32, m64;

  // Element index is beat * elems_per_reg + k; the shift is the multiply.
  for (genvar k = 0; k < 16; k++) begin : g_e8
    logic [8:0] idx;
    assign idx = {2'b0, beat, 4'b0} + 9'(k);
    assign m8[k*8 +: 8] = (idx >= vl) ? '1 : in_data[k*8 +: 8];
  end

  for (genvar k = 0; k < 8; k++) begin : g_e16
    logic [8:0] idx;
    assign idx = {3'b0, beat, 3'b0} + 9'(k);
    assign m16[k*16 +: 16] = (idx >= vl) ? '1 : in_data[k*16 +: 16];
  end

  for (genvar k = 0; k < 4; k++) begin : g_e32
    logic [8:0] idx;
    assign idx = {4'b0, beat, 2'b0} + 9'(k);
    assign m32[k*32 +: 32] = (idx >= vl) ? '1 : in_data[k*32 +: 32];
  end

  for (genvar k = 0; k < 2; k++) begin : g_e64
    logic [8:0] idx;
    assign idx = {5'b0, beat, 1'b0} + 9'(k);
    assign m64[k*64 +: 64] = (idx >= vl) ? '1 : in_data[k*64 +: 64];
  end

  always_comb begin
    out_data = m8;
    unique case (sew)
      2'b00: out_data = m8;
      2'b01: out_data = m16;
      2'b10: out_data = m32;
      2'b11: out_data = m64;
    endcase
  end

endmodule

// File: rtl/vec_wb_sequencer.sv
// Writeback sequencer from the vector ALU to the VRF write port. One start
// configures a destination group; one beat per register is then accepted and
// written to vd..vd+nregs-1 with tail elements forced to all ones.
// Ports:
//   clk, rst          - clock, synchronous active-low reset
//   start             - configuration strobe (honoured only when idle)
//   vd, sew_enc,
//   lmul_enc, vl      - group configuration, latched on an accepted start
//   in_valid/in_ready - beat handshake, in_data carries register vd+beat
//   wen, wa, wd       - registered register-file write port
//   busy              - group in progress, includes the final write cycle
//   done              - one-cycle pulse with the last write (or for vl==0)
//   err               - one-cycle pulse on an illegal configuration
module vec_wb_sequencer
  import rvv_pkg::*;
#(
  parameter int unsigned VLEN = 128,
  parameter int unsigned AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AW-1:0]   vd,
  input  logic [2:0]      sew_enc,
  input  logic [2:0]      lmul_enc,
  input  logic [8:0]      vl,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [VLEN-1:0] in_data,
  output logic            wen,
  output logic [AW-1:0]   wa,
  output logic [VLEN-1:0] wd,
  output logic            busy,
  output logic            done,
  output logic            err
);

  wb_state_e       state_q, state_d;
  logic [AW-1:0]   vd_q, vd_d;
  logic [1:0]      sew_q, sew_d;
  logic [3:0]      nregs_q, nregs_d;
  logic [8:0]      vl_q, vl_d;
  logic [2:0]      beat_q, beat_d;
  logic            wen_q, wen_d;
  logic [AW-1:0]   wa_q, wa_d;
  logic [VLEN-1:0] wd_q, wd_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [3:0]      cfg_nregs;
  logic            cfg_bad;
  logic [VLEN-1:0] masked;

  vwb_tail_mask u_tail_mask (
    .in_data  (in_data),
    .sew      (sew_q),
    .beat     (beat_q),
    .vl       (vl_q),
    .out_data (masked)
  );

  assign cfg_nregs = lmul_nregs(lmul_enc);
  // Group base must be aligned to the group size
  assign cfg_bad   = !sew_legal(sew_enc) || !lmul_legal(lmul_enc) ||
                     ((vd & AW'(cfg_nregs - 4'd1)) != '0);

  assign in_ready = (state_q == StActive);

  always_comb begin
    state_d = state_q;
    vd_d    = vd_q;
    sew_d   = sew_q;
    nregs_d = nregs_q;
    vl_d    = vl_q;
    beat_d  = beat_q;
    wen_d   = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (cfg_bad) begin
            err_d = 1'b1;
          end else if (vl == '0) begin
            state_d = StFinish;
          end else begin
            vd_d    = vd;
            sew_d   = sew_enc[1:0];
            nregs_d = cfg_nregs;
            vl_d    = vl;
            beat_d  = '0;
            state_d = StActive;
          end
        end
      end
      StActive: begin
        if (in_valid) begin
          wen_d  = 1'b1;
          wa_d   = vd_q + AW'(beat_q);
          wd_d   = masked;
          beat_d = beat_q + 3'd1;
          if ({1'b0, beat_q} == nregs_q - 4'd1) begin
            done_d  = 1'b1;
            beat_d  = '0;
            state_d = StIdle;
          end
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // done_d keeps busy up through the final write cycle
    busy_d = (state_d != StIdle) || done_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      vd_q    <= '0;
      sew_q   <= '0;
      nregs_q <= '0;
      vl_q    <= '0;
      beat_q  <= '0;
      wen_q   <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vd_q    <= vd_d;
      sew_q   <= sew_d;
      nregs_q <= nregs_d;
      vl_q    <= vl_d;
      beat_q  <= beat_d;
      wen_q   <= wen_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign wen  = wen_q;
  assign wa   = wa_q;
  assign wd   = wd_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_vec_wb_sequencer.sv
// Directed bench for vec_wb_sequencer. Inputs change 1 time unit after a
// rising edge; outputs are sampled at that same point.
module tb_vec_wb_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [4:0]   vd;
  logic [2:0]   sew_enc;
  logic [2:0]   lmul_enc;
  logic [8:0]   vl;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         wen;
  logic [4:0]   wa;
  logic [127:0] wd;
  logic         busy;
  logic         done;
  logic         err;

  int num_checks = 0;
  int num_fails  = 0;

  always #5 clk = ~clk;

  vec_wb_sequencer #(
    .VLEN (128),
    .AW   (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .vd       (vd),
    .sew_enc  (sew_enc),
    .lmul_enc (lmul_enc),
    .vl       (vl),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .wen      (wen),
    .wa       (wa),
    .wd       (wd),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [4:0] v, input logic [2:0] s, input logic [2:0] l,
                     input logic [8:0] n);
    vd       = v;
    sew_enc  = s;
    lmul_enc = l;
    vl       = n;
    start    = 1'b1;
  endtask

  task automatic check_write(input string tag, input logic [4:0] exp_wa,
                             input logic [127:0] exp_wd, input logic exp_done);
    check({tag, ".wen"}, 128'(wen), 128'(1'b1));
    check({tag, ".wa"}, 128'(wa), 128'(exp_wa));
    check({tag, ".wd"}, wd, exp_wd);
    check({tag, ".done"}, 128'(done), 128'(exp_done));
  endtask

  task automatic check_quiet(input string tag, input logic exp_busy);
    check({tag, ".wen"}, 128'(wen), 128'(1'b0));
    check({tag, ".done"}, 128'(done), 128'(1'b0));
    check({tag, ".busy"}, 128'(busy), 128'(exp_busy));
  endtask

  logic [127:0] exp_t2 [4];

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    vd       = '0;
    sew_enc  = '0;
    lmul_enc = '0;
    vl       = '0;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset state
    step();
    step();
    check("rst.in_ready", 128'(in_ready), 128'(1'b0));
    check("rst.wen", 128'(wen), 128'(1'b0));
    check("rst.wa", 128'(wa), 128'(5'd0));
    check("rst.wd", wd, 128'd0);
    check("rst.busy", 128'(busy), 128'(1'b0));
    check("rst.done", 128'(done), 128'(1'b0));
    check("rst.err", 128'(err), 128'(1'b0));
    rst = 1'b1;
    step();

    // T1: SEW=32 LMUL=1 vd=3 vl=2, upper two words are tail
    cfg(5'd3, 3'b010, 3'b000, 9'd2);
    step();
    start = 1'b0;
    check("t1.in_ready", 128'(in_ready), 128'(1'b1));
    check("t1.busy", 128'(busy), 128'(1'b1));
    in_valid = 1'b1;
    in_data  = 128'h88887777_66665555_44443333_22221111;
    step();
    in_valid = 1'b0;
    check_write("t1", 5'd3, 128'hFFFFFFFF_FFFFFFFF_44443333_22221111, 1'b1);
    check("t1.busy_last", 128'(busy), 128'(1'b1));
    step();
    check_quiet("t1.after", 1'b0);

    // T2: SEW=8 LMUL=4 vd=8 vl=40, beat 2 half tail, beat 3 all tail
    exp_t2[0] = 128'h0;
    exp_t2[1] = 128'h0;
    exp_t2[2] = 128'hFFFFFFFFFFFFFFFF_0000000000000000;
    exp_t2[3] = {128{1'b1}};
    cfg(5'd8, 3'b000, 3'b010, 9'd40);
    step();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = '0;
    for (int b = 0; b < 4; b++) begin
      step();
      check_write($sformatf("t2.b%0d", b), 5'(8 + b), exp_t2[b], b == 3);
    end
    in_valid = 1'b0;
    check("t2.ready_off", 128'(in_ready), 128'(1'b0));
    step();
    check_quiet("t2.after", 1'b0);

    // T3: LMUL=2 with odd vd is rejected
    cfg(5'd5, 3'b000, 3'b001, 9'd4);
    step();
    start = 1'b0;
    check("t3.err", 128'(err), 128'(1'b1));
    check("t3.busy", 128'(busy), 128'(1'b0));
    check("t3.wen", 128'(wen), 128'(1'b0));
    check("t3.in_ready", 128'(in_ready), 128'(1'b0));
    step();
    check("t3.err_pulse", 128'(err), 128'(1'b0));
    check_quiet("t3.after", 1'b0);

    // T4: vl=0 goes straight to done, no beats taken
    cfg(5'd0, 3'b001, 3'b011, 9'd0);
    in_valid = 1'b1;
    step();
    start = 1'b0;
    check("t4.in_ready0", 128'(in_ready), 128'(1'b0));
    check_quiet("t4.c1", 1'b1);
    step();
    check("t4.done", 128'(done), 128'(1'b1));
    check("t4.wen", 128'(wen), 128'(1'b0));
    check("t4.in_ready1", 128'(in_ready), 128'(1'b0));
    in_valid = 1'b0;
    step();
    check_quiet("t4.after", 1'b0);

    // T5: SEW=64 LMUL=2 vd=4 vl=4, stalled beats, ignored mid-group start
    cfg(5'd4, 3'b011, 3'b001, 9'd4);
    step();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 128'h0123456789ABCDEF_FEDCBA9876543210;
    step();
    check_write("t5.b0", 5'd4, 128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0);
    in_valid = 1'b0;
    cfg(5'd3, 3'b000, 3'b001, 9'd1);
    step();
    start = 1'b0;
    check_quiet("t5.stall1", 1'b1);
    check("t5.err", 128'(err), 128'(1'b0));
    check("t5.in_ready", 128'(in_ready), 128'(1'b1));
    step();
    check_quiet("t5.stall2", 1'b1);
    in_valid = 1'b1;
    in_data  = 128'hAAAA5555AAAA5555_1234123412341234;
    step();
    in_valid = 1'b0;
    check_write("t5.b1", 5'd5, 128'hAAAA5555AAAA5555_1234123412341234, 1'b1);
    step();
    check_quiet("t5.after", 1'b0);

    // T6: reset after the first beat of an LMUL=8 group
    cfg(5'd8, 3'b000, 3'b011, 9'd128);
    step();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = {16{8'h11}};
    step();
    check_write("t6.b0", 5'd8, {16{8'h11}}, 1'b0);
    rst = 1'b0;
    step();
    check_quiet("t6.rst", 1'b0);
    check("t6.rst_ready", 128'(in_ready), 128'(1'b0));
    rst      = 1'b1;
    in_valid = 1'b0;
    step();
    check_quiet("t6.idle", 1'b0);
    check("t6.idle_ready", 128'(in_ready), 128'(1'b0));

    // Fresh start after reset: SEW=16 LMUL=1 vd=2 vl=5
    cfg(5'd2, 3'b001, 3'b000, 9'd5);
    step();
    start = 1'b0;
    check("t6.fresh_ready", 128'(in_ready), 128'(1'b1));
    in_valid = 1'b1;
    in_data  = {16{8'h5A}};
    step();
    in_valid = 1'b0;
    check_write("t6.fresh", 5'd2, {48'hFFFF_FFFF_FFFF, {10{8'h5A}}}, 1'b1);
    // New start in the done cycle is taken (vl=0 group)
    cfg(5'd0, 3'b000, 3'b000, 9'd0);
    step();
    start = 1'b0;
    check_quiet("t6.b2b", 1'b1);
    step();
    check("t6.b2b_done", 128'(done), 128'(1'b1));
    step();
    check_quiet("t6.end", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_fails);
    $finish;
  end

endmodule
